// File: rtl/rnn_pkg.sv
// Shared types and helpers for the RNN activation datapath.
package rnn_pkg;

  typedef enum logic [1:0] {
    ACT_ID    = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_HSIG  = 2'd2,
    ACT_HTANH = 2'd3
  } act_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } act_state_e;

  localparam int Q_FRAC = 8;

  // Clamp a 17-bit signed sum into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7FFF;
    return v[15:0];
  endfunction

endpackage

// File: rtl/act_pwl.sv
// Combinational piecewise-linear activation of one signed fixed-point element.
module act_pwl
  import rnn_pkg::*;
#(
  parameter int FRAC_BITS = Q_FRAC
) (
  input  logic signed [15:0] s,
  input  act_e               act_sel,
  output logic signed [15:0] y
);

  localparam logic signed [17:0] ONE     = 18'sd1 <<< FRAC_BITS;
  localparam logic signed [17:0] HALF    = ONE >>> 1;
  localparam logic signed [17:0] NEG_ONE = -ONE;

  logic signed [17:0] s_ext;
  logic signed [17:0] hs;

  // Two guard bits so the sigmoid offset and the clamp compares cannot overflow.
  assign s_ext = {{2{s[15]}}, s};
  assign hs    = (s_ext >>> 2) + HALF;

  always_comb begin
    y = s;
    case (act_sel)
      ACT_ID:   y = s;
      ACT_RELU: if (s[15]) y = '0;
      ACT_HSIG: begin
        if (hs[17])        y = '0;
        else if (hs > ONE) y = ONE[15:0];
        else               y = hs[15:0];
      end
      ACT_HTANH: begin
        if (s_ext > ONE)          y = ONE[15:0];
        else if (s_ext < NEG_ONE) y = NEG_ONE[15:0];
      end
      default: y = s;
    endcase
  end

endmodule

// File: rtl/rnn_activation.sv
// Bias-add + activation stage between the matmul stream and the hidden-state buffer.
// Optional bias RAM is enabled with the RNN_ACT_BIAS_EN macro.
module rnn_activation
  import rnn_pkg::*;
#(
  parameter int LEN_BITS  = 4,
  parameter int FRAC_BITS = Q_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_BITS:0]   len,
  input  logic [1:0]          act_sel,
  input  logic                in_valid,
  input  logic [15:0]         in_data,
  output logic                in_ready,
  input  logic                bias_we,
  input  logic [LEN_BITS-1:0] bias_addr,
  input  logic [15:0]         bias_data,
  output logic                out_valid,
  output logic [15:0]         out_data,
  output logic [LEN_BITS-1:0] out_idx,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output act_state_e          state_dbg
);

  localparam logic [LEN_BITS:0] CNT_ONE = (LEN_BITS+1)'(1);

  act_state_e          state;
  act_e                act_q;
  logic [LEN_BITS:0]   len_q, in_cnt, out_cnt;
  logic                stall, accept, out_fire, last_out;
  logic                s1_valid;
  logic signed [15:0]  s1_data;
  logic [LEN_BITS-1:0] s1_idx;
  logic signed [15:0]  bias_v;
  logic signed [16:0]  sum;
  logic signed [15:0]  act_y;

  // Handshake: a transfer happens on any cycle where valid && ready; valid never
  // waits on ready, and a presented output holds its data until accepted.
  assign stall     = out_valid && !out_ready;
  assign in_ready  = (state == RUN) && (in_cnt < len_q) && !stall;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_out  = out_fire && (out_cnt == len_q - CNT_ONE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

`ifdef RNN_ACT_BIAS_EN
  logic signed [15:0] bias_mem [2**LEN_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**LEN_BITS; i++) bias_mem[i] <= '0;
    end else if (bias_we && (state == IDLE)) begin
      bias_mem[bias_addr] <= bias_data;
    end
  end

  assign bias_v = bias_mem[in_cnt[LEN_BITS-1:0]];
`else
  logic unused_bias;
  assign unused_bias = ^{bias_we, bias_addr, bias_data};
  assign bias_v      = '0;
`endif

  assign sum = {in_data[15], in_data} + {bias_v[15], bias_v};

  act_pwl #(.FRAC_BITS(FRAC_BITS)) u_act (
    .s       (s1_data),
    .act_sel (act_q),
    .y       (act_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      act_q   <= ACT_ID;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_q   <= len;
          act_q   <= act_e'(act_sel);
          in_cnt  <= '0;
          out_cnt <= '0;
          state   <= (len == '0) ? DONE : RUN;
        end
        RUN: begin
          if (accept)   in_cnt  <= in_cnt + CNT_ONE;
          if (out_fire) out_cnt <= out_cnt + CNT_ONE;
          if (last_out) state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Both stages advance together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (!stall) begin
      s1_valid  <= accept;
      if (accept) begin
        s1_data <= sat16(sum);
        s1_idx  <= in_cnt[LEN_BITS-1:0];
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= act_y;
        out_idx  <= s1_idx;
      end
    end
  end

endmodule
